led_pattern_seq: RTL

- Parametrised successor to the single-mode rotating LED driver on the Tang Nano 9K board.
- Drives an N_LED-wide LED bank from a programmable tick divider.
- Four selectable pattern modes: rotate left, rotate right, bounce and binary count.
- Per-bank PWM brightness and configurable output polarity.
- Sits in top beside the video path and runs on the crystal clock domain.

---
 rtl/led_pattern_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/led_pattern_seq.sv
// Pattern sequencer for an N_LED-wide LED bank: tick divider, four pattern modes,
// PWM brightness and selectable output polarity. Runs entirely in the CLK domain.
module led_pattern_seq #(
    parameter int N_LED      = 6,
    parameter int TICK_DIV   = 4000000,
    parameter int PWM_BITS   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                CLK,
    input  logic                ARST,
    input  logic                EN,
    input  logic [1:0]          MODE,
    input  logic [PWM_BITS-1:0] BRIGHT,
    output logic                TICK,
    output logic [N_LED-1:0]    LED
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [N_LED-1:0]    PAT_ONE  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0]    LED_RST  = ACTIVE_LOW ? ~PAT_ONE : PAT_ONE;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    logic [CNT_W-1:0]    r_tick_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [N_LED-1:0]    r_pat;
    dir_t                r_dir;
    mode_t               r_mode;
    logic                r_tick;
    logic [N_LED-1:0]    r_led;

    logic [CNT_W-1:0]    w_tick_cnt_nxt;
    logic [N_LED-1:0]    w_pat_nxt;
    dir_t                w_dir_nxt;
    mode_t               w_mode_nxt;
    logic                w_mode_chg;
    logic                w_at_last;
    logic                w_step;
    logic                w_on;

    function automatic logic [N_LED-1:0] led_image(input logic [N_LED-1:0] lit);
        return ACTIVE_LOW ? ~lit : lit;
    endfunction

    // A mode change takes priority over a coincident step and restarts the divider.
    always_comb begin
        w_mode_chg = (mode_t'(MODE) != r_mode);
        w_at_last  = (r_tick_cnt == CNT_LAST);
        w_step     = EN && w_at_last && !w_mode_chg;
        w_on       = (BRIGHT == '1) || (r_pwm_cnt < BRIGHT);
    end

    always_comb begin
        w_tick_cnt_nxt = r_tick_cnt;
        w_pat_nxt      = r_pat;
        w_dir_nxt      = r_dir;
        w_mode_nxt     = r_mode;
        if (w_mode_chg) begin
            w_mode_nxt     = mode_t'(MODE);
            w_tick_cnt_nxt = '0;
            w_dir_nxt      = DIR_LEFT;
            w_pat_nxt      = (mode_t'(MODE) == MODE_COUNT) ? '0 : PAT_ONE;
        end else if (EN) begin
            w_tick_cnt_nxt = w_at_last ? '0 : r_tick_cnt + CNT_ONE;
            if (w_at_last) begin
                case (r_mode)
                    MODE_ROTL: w_pat_nxt = {r_pat[N_LED-2:0], r_pat[N_LED-1]};
                    MODE_ROTR: w_pat_nxt = {r_pat[0], r_pat[N_LED-1:1]};
                    MODE_BOUNCE: begin
                        // Reversing at an end moves away immediately, so end LEDs last one step.
                        if (r_dir == DIR_LEFT) begin
                            if (r_pat[N_LED-1]) begin
                                w_dir_nxt = DIR_RIGHT;
                                w_pat_nxt = r_pat >> 1;
                            end else begin
                                w_pat_nxt = r_pat << 1;
                            end
                        end else begin
                            if (r_pat[0]) begin
                                w_dir_nxt = DIR_LEFT;
                                w_pat_nxt = r_pat << 1;
                            end else begin
                                w_pat_nxt = r_pat >> 1;
                            end
                        end
                    end
                    MODE_COUNT: w_pat_nxt = r_pat + PAT_ONE;
                    default:    w_pat_nxt = r_pat;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_tick_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_pat      <= PAT_ONE;
            r_dir      <= DIR_LEFT;
            r_mode     <= MODE_ROTL;
            r_tick     <= 1'b0;
            r_led      <= LED_RST;
        end else begin
            r_tick_cnt <= w_tick_cnt_nxt;
            r_pwm_cnt  <= r_pwm_cnt + PWM_ONE;
            r_pat      <= w_pat_nxt;
            r_dir      <= w_dir_nxt;
            r_mode     <= w_mode_nxt;
            r_tick     <= w_step;
            r_led      <= led_image(r_pat & {N_LED{w_on}});
        end
    end

    assign TICK = r_tick;
    assign LED  = r_led;

endmodule
